// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg
// Shared definitions for the gate sweep sequencer:
//   - state_t : FSM state encoding (IDLE, APPLY, DONE)
//   - TT_*    : expected truth tables for common two-input gates;
//               bit i is the expected output for input vector i = {a,b}.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] TT_OR  = 4'b1110;
  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_XOR = 4'b0110;
  localparam logic [3:0] TT_NOR = 4'b0001;

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// gate_sweep_ctrl_if
// Bundles the sequencer's control/status and gate-under-test signals.
//   start     : begin a sweep (from board control)
//   a, b      : gate inputs driven by the sequencer
//   c         : gate output under test
//   busy      : sweep in progress
//   done      : one-cycle completion pulse
//   pass      : last sweep had no mismatches
//   err_mask  : per-vector mismatch flags of the last sweep
//   vec_idx   : index of the vector currently applied
//   fail_cnt  : saturating count of failed sweeps (only with GATE_SWEEP_FAILCNT_EN)
// Modports: master = sequencer, slave = board control plus gate.
interface gate_sweep_ctrl_if;

  logic       start;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_mask;
  logic [1:0] vec_idx;
`ifdef GATE_SWEEP_FAILCNT_EN
  logic [7:0] fail_cnt;

  modport master (
    input  start, c,
    output a, b, busy, done, pass, err_mask, vec_idx, fail_cnt
  );

  modport slave (
    output start, c,
    input  a, b, busy, done, pass, err_mask, vec_idx, fail_cnt
  );
`else
  modport master (
    input  start, c,
    output a, b, busy, done, pass, err_mask, vec_idx
  );

  modport slave (
    output start, c,
    input  a, b, busy, done, pass, err_mask, vec_idx
  );
`endif

endinterface

// File: rtl/gate_dwell_timer.sv
// gate_dwell_timer
// 8-bit dwell counter. Counts while en is high, wraps to 0 after reaching
// DWELL-1, and is forced to 0 by clr or rst.
//   clk : clock
//   rst : synchronous active-high reset
//   en  : count enable
//   clr : synchronous clear (dominates en)
//   tc  : terminal count, high while the count equals DWELL-1
module gate_dwell_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(DWELL - 1);

  logic [7:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values and updates together.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? 8'd0 : cnt + 8'd1;
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl
// Drives a two-input gate through vectors 00,01,10,11, holds each for DWELL
// cycles, samples the gate output on the last dwell cycle and compares it
// with TRUTH. Reports per-vector mismatches (err_mask) and an overall pass.
// Parameters:
//   DWELL : cycles each vector is held (2..255)
//   TRUTH : expected output table, bit i for vector i = {a,b}
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : gate_sweep_ctrl_if.master (start, a, b, c, busy, done, pass,
//          err_mask, vec_idx, and fail_cnt when enabled)
// Build option: define GATE_SWEEP_FAILCNT_EN to add the saturating
// fail_cnt output counting sweeps that ended with a non-zero err_mask.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter logic [3:0]  TRUTH = TT_OR
) (
  input  logic               clk,
  input  logic               rst,
  gate_sweep_ctrl_if.master  bus
);

  state_t     state;
  logic       tc;
  logic       a_q;
  logic       b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] err_q;
  logic [1:0] vec_q;

  // Timer runs only in APPLY; holding it cleared elsewhere guarantees every
  // sweep starts from a zero count.
  gate_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk (clk),
    .rst (rst),
    .en  (state == APPLY),
    .clr (state != APPLY),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      vec_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            err_q        <= '0;
            pass_q       <= 1'b0;
            vec_q        <= 2'd0;
            {a_q, b_q}   <= 2'b00;
            busy_q       <= 1'b1;
            state        <= APPLY;
          end
        end
        APPLY: begin
          if (tc) begin
            // c is sampled only here, so the gate may settle for up to
            // DWELL-1 cycles after the vector changes.
            err_q[vec_q] <= (bus.c != TRUTH[vec_q]);
            if (vec_q == 2'd3) begin
              {a_q, b_q} <= 2'b00;
              busy_q     <= 1'b0;
              state      <= DONE;
            end else begin
              vec_q      <= vec_q + 2'd1;
              {a_q, b_q} <= vec_q + 2'd1;
            end
          end
        end
        DONE: begin
          // err_q already holds the last vector's result at this point.
          done_q <= 1'b1;
          pass_q <= (err_q == 4'd0);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_mask = err_q;
  assign bus.vec_idx  = vec_q;

`ifdef GATE_SWEEP_FAILCNT_EN
  logic [7:0] fail_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_q <= '0;
    end else if (state == DONE && err_q != 4'd0 && fail_q != 8'hFF) begin
      fail_q <= fail_q + 8'd1;
    end
  end

  assign bus.fail_cnt = fail_q;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl
// Directed bench for gate_sweep_ctrl: a table of gate models with expected
// err_mask/pass, plus hand-written sequences for cycle timing, ignored
// mid-sweep starts, back-to-back sweeps, reset behaviour, settling tolerance
// and (with GATE_SWEEP_FAILCNT_EN) fail_cnt saturation.
module tb_gate_sweep_ctrl;
  import gate_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_sweep_ctrl_if m_if ();
  gate_sweep_ctrl_if s3_if ();
  gate_sweep_ctrl_if s2_if ();

  gate_sweep_ctrl #(.DWELL(4), .TRUTH(TT_OR)) dut (
    .clk (clk), .rst (rst), .bus (m_if)
  );
  gate_sweep_ctrl #(.DWELL(3), .TRUTH(TT_OR)) dut_d3 (
    .clk (clk), .rst (rst), .bus (s3_if)
  );
  gate_sweep_ctrl #(.DWELL(2), .TRUTH(TT_OR)) dut_d2 (
    .clk (clk), .rst (rst), .bus (s2_if)
  );

  // Gate models
  typedef enum int {M_IDEAL, M_STUCK0, M_DELAY2, M_STUCK1, M_XOR} model_t;
  model_t mode;

  logic m_d1, m_d2, s3_d1, s3_d2, s2_d1, s2_d2;
  always @(posedge clk) begin
    m_d1  <= m_if.a | m_if.b;
    m_d2  <= m_d1;
    s3_d1 <= s3_if.a | s3_if.b;
    s3_d2 <= s3_d1;
    s2_d1 <= s2_if.a | s2_if.b;
    s2_d2 <= s2_d1;
  end

  // NOTE: default assignment first keeps this purely combinational.
  always_comb begin
    m_if.c = 1'b0;
    case (mode)
      M_IDEAL:  m_if.c = m_if.a | m_if.b;
      M_STUCK0: m_if.c = 1'b0;
      M_DELAY2: m_if.c = m_d2;
      M_STUCK1: m_if.c = 1'b1;
      M_XOR:    m_if.c = m_if.a ^ m_if.b;
      default:  m_if.c = 1'b0;
    endcase
  end

  always_comb s3_if.c = s3_d2;
  always_comb s2_if.c = s2_d2;

  int n_checks;
  int n_pass;
`ifdef GATE_SWEEP_FAILCNT_EN
  int exp_fail;
`endif

  typedef struct {
    string      name;
    model_t     md;
    logic [3:0] exp_mask;
    logic       exp_pass;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_sweep(input logic [3:0] mask);
`ifdef GATE_SWEEP_FAILCNT_EN
    if (mask != 4'd0 && exp_fail < 255) exp_fail++;
`else
    if (mask != 4'd0) begin end
`endif
  endtask

  // Pulse start on the main DUT and wait (bounded) for done.
  task automatic run_sweep(input model_t md);
    bit got;
    mode = md;
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (m_if.done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(got), 32'd1);
  endtask

  // Cycle-accurate sweep with an ideal gate; k counts edges after the
  // accepting edge. Optional start pulses mid-sweep must be ignored.
  task automatic timed_sweep(input bit pulses);
    mode = M_IDEAL;
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      check($sformatf("t%0d_busy", k), 32'(m_if.busy), (k < 16) ? 32'd1 : 32'd0);
      check($sformatf("t%0d_ab", k), 32'({m_if.a, m_if.b}), (k < 16) ? 32'(k / 4) : 32'd0);
      check($sformatf("t%0d_vec", k), 32'(m_if.vec_idx), (k < 16) ? 32'(k / 4) : 32'd3);
      check($sformatf("t%0d_done", k), 32'(m_if.done), (k == 17) ? 32'd1 : 32'd0);
      m_if.start = (pulses && (k == 3 || k == 10)) ? 1'b1 : 1'b0;
      tick();
    end
    m_if.start = 1'b0;
    check("timed_pass", 32'(m_if.pass), 32'd1);
    check("timed_mask", 32'(m_if.err_mask), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit saw_done;

    tbl[0] = '{"ideal",   M_IDEAL,  4'b0000, 1'b1};
    tbl[1] = '{"stuck0",  M_STUCK0, 4'b1110, 1'b0};
    tbl[2] = '{"delay2",  M_DELAY2, 4'b0000, 1'b1};
    tbl[3] = '{"stuck1",  M_STUCK1, 4'b0001, 1'b0};
    tbl[4] = '{"xor",     M_XOR,    4'b1000, 1'b0};
    tbl[5] = '{"ideal2",  M_IDEAL,  4'b0000, 1'b1};

    n_checks = 0;
    n_pass   = 0;
`ifdef GATE_SWEEP_FAILCNT_EN
    exp_fail = 0;
`endif
    mode        = M_IDEAL;
    m_if.start  = 1'b0;
    s3_if.start = 1'b0;
    s2_if.start = 1'b0;
    rst = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_a", 32'(m_if.a), 32'd0);
    check("rst_b", 32'(m_if.b), 32'd0);
    check("rst_busy", 32'(m_if.busy), 32'd0);
    check("rst_done", 32'(m_if.done), 32'd0);
    check("rst_pass", 32'(m_if.pass), 32'd0);
    check("rst_mask", 32'(m_if.err_mask), 32'd0);
    check("rst_vec", 32'(m_if.vec_idx), 32'd0);
`ifdef GATE_SWEEP_FAILCNT_EN
    check("rst_fail_cnt", 32'(m_if.fail_cnt), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Exact timing, then again with ignored start pulses at cycles 3 and 10
    timed_sweep(1'b0);
    timed_sweep(1'b1);

    // Table of gate models
    for (int i = 0; i < 6; i++) begin
      run_sweep(tbl[i].md);
      note_sweep(tbl[i].exp_mask);
      check({tbl[i].name, "_mask"}, 32'(m_if.err_mask), 32'(tbl[i].exp_mask));
      check({tbl[i].name, "_pass"}, 32'(m_if.pass), 32'(tbl[i].exp_pass));
`ifdef GATE_SWEEP_FAILCNT_EN
      check({tbl[i].name, "_fail_cnt"}, 32'(m_if.fail_cnt), 32'(exp_fail));
`endif
    end

    // Results hold in IDLE after a failing sweep
    run_sweep(M_STUCK0);
    note_sweep(4'b1110);
    repeat (5) tick();
    check("hold_mask", 32'(m_if.err_mask), 32'b1110);
    check("hold_pass", 32'(m_if.pass), 32'd0);
    check("hold_vec", 32'(m_if.vec_idx), 32'd3);
    check("hold_busy", 32'(m_if.busy), 32'd0);

    // Start held high: back-to-back sweeps every 18 cycles
    mode = M_IDEAL;
    m_if.start = 1'b1;
    tick();
    for (int k = 0; k < 56; k++) begin
      check($sformatf("b2b%0d_done", k), 32'(m_if.done), ((k % 18) == 17) ? 32'd1 : 32'd0);
      check($sformatf("b2b%0d_busy", k), 32'(m_if.busy), ((k % 18) < 16) ? 32'd1 : 32'd0);
      tick();
    end
    m_if.start = 1'b0;
    repeat (25) tick();
    check("b2b_pass", 32'(m_if.pass), 32'd1);

    // rst and start in the same cycle: rst wins
    rst = 1'b1;
    m_if.start = 1'b1;
    tick();
    rst = 1'b0;
    m_if.start = 1'b0;
`ifdef GATE_SWEEP_FAILCNT_EN
    exp_fail = 0;
`endif
    check("rst_start_busy", 32'(m_if.busy), 32'd0);
    check("rst_start_pass", 32'(m_if.pass), 32'd0);
    tick();
    check("rst_start_idle", 32'(m_if.busy), 32'd0);

    // rst mid-sweep with a partial err_mask
    mode = M_STUCK1;
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    repeat (6) tick();
    check("mid_partial_mask", 32'(m_if.err_mask), 32'b0001);
    check("mid_busy_before", 32'(m_if.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", 32'(m_if.busy), 32'd0);
    check("mid_ab", 32'({m_if.a, m_if.b}), 32'd0);
    check("mid_mask", 32'(m_if.err_mask), 32'd0);
    check("mid_vec", 32'(m_if.vec_idx), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_if.done) saw_done = 1'b1;
      tick();
    end
    check("mid_no_done", 32'(saw_done), 32'd0);
    run_sweep(M_IDEAL);
    check("mid_fresh_mask", 32'(m_if.err_mask), 32'd0);
    check("mid_fresh_pass", 32'(m_if.pass), 32'd1);
`ifdef GATE_SWEEP_FAILCNT_EN
    check("mid_fail_cnt", 32'(m_if.fail_cnt), 32'd0);
`endif

    // Settling tolerance: 2-cycle gate delay with DWELL=3 and DWELL=2
    s3_if.start = 1'b1;
    s2_if.start = 1'b1;
    tick();
    s3_if.start = 1'b0;
    s2_if.start = 1'b0;
    repeat (20) tick();
    check("d3_mask", 32'(s3_if.err_mask), 32'd0);
    check("d3_pass", 32'(s3_if.pass), 32'd1);
    check("d2_mask", 32'(s2_if.err_mask), 32'b0010);
    check("d2_pass", 32'(s2_if.pass), 32'd0);

`ifdef GATE_SWEEP_FAILCNT_EN
    // fail_cnt saturation
    for (int i = 0; i < 260; i++) begin
      run_sweep(M_STUCK0);
      note_sweep(4'b1110);
    end
    check("sat_fail_cnt", 32'(m_if.fail_cnt), 32'(exp_fail));
    check("sat_fail_cnt_255", 32'(m_if.fail_cnt), 32'd255);
    run_sweep(M_IDEAL);
    check("sat_after_start", 32'(m_if.fail_cnt), 32'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
